// File: rtl/fir_pkg.sv
`default_nettype none
// ==========================================================================
// fir_pkg: Q-format constants and sample types shared by the FIR chain. Rev 1.0
// ==========================================================================
package fir_pkg;

  localparam int IN_FRAC  = 27;
  localparam int OUT_FRAC = 15;
  localparam int Q_SHIFT  = IN_FRAC - OUT_FRAC;

  localparam logic signed [15:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] OUT_MIN = 16'sh8000;

  typedef logic signed [31:0] sample_in_t;
  typedef logic signed [15:0] sample_out_t;

endpackage
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// ==========================================================================
// fir_sync_fifo: show-ahead synchronous FIFO with level count and sync clear. Rev 1.0
// ==========================================================================
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;

  logic w_pop;
  logic w_push;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LW'(DEPTH));
  assign w_pop  = pop & ~empty;
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

  // Storage is not reset, so the head is masked while empty.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/fir_decim_out_stage.sv
`default_nettype none
// ==========================================================================
// fir_decim_out_stage: decimate FIR stream, requantise Q5.27->Q1.15, FIFO out. Rev 1.0
// ==========================================================================
module fir_decim_out_stage
  import fir_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IN_W-1:0]               din,
  input  logic                          din_valid,
  input  logic                          flush,
  input  logic                          clr_flags,
  output logic [OUT_W-1:0]              m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_sticky,
  output logic                          ovf_sticky
);

  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int EXT_W = IN_W + 1;

  localparam logic signed [EXT_W-1:0] C_BIAS    = EXT_W'(1) << (Q_SHIFT - 1);
  localparam logic signed [EXT_W-1:0] C_MAX_EXT = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] C_MIN_EXT = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [PH_W-1:0]  phase_q,      phase_d;
  logic [OUT_W-1:0] conv_q,       conv_d;
  logic             conv_valid_q, conv_valid_d;
  logic             sat_q,        sat_d;
  logic             ovf_q,        ovf_d;

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_sum;
  logic signed [EXT_W-1:0] w_shift;
  logic                    w_clip_hi;
  logic                    w_clip_lo;
  logic [OUT_W-1:0]        w_sat_val;
  logic                    w_keep;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;

  // One guard bit keeps the signed bias add from wrapping at the extremes.
  assign w_ext     = {din[IN_W-1], din};
  assign w_sum     = din[IN_W-1] ? (w_ext - C_BIAS) : (w_ext + C_BIAS);
  assign w_shift   = w_sum >>> Q_SHIFT;
  assign w_clip_hi = (w_shift > C_MAX_EXT);
  assign w_clip_lo = (w_shift < C_MIN_EXT);

  always_comb begin
    w_sat_val = w_shift[OUT_W-1:0];
    if (w_clip_hi)      w_sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_clip_lo) w_sat_val = {1'b1, {(OUT_W-1){1'b0}}};
  end

  assign w_keep = din_valid & (phase_q == '0);
  assign w_pop  = m_valid & m_ready;
  assign w_push = conv_valid_q & ~flush;
  assign w_drop = w_push & w_full & ~w_pop;

  always_comb begin
    phase_d = phase_q;
    if (flush) begin
      phase_d = '0;
    end else if (din_valid) begin
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
    end

    conv_valid_d = w_keep & ~flush;
    conv_d       = conv_valid_d ? w_sat_val : conv_q;

    // A set event in the same cycle as clr_flags wins.
    sat_d = (sat_q & ~clr_flags) | (conv_valid_d & (w_clip_hi | w_clip_lo));
    ovf_d = (ovf_q & ~clr_flags) | w_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= '0;
      conv_q       <= '0;
      conv_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      conv_q       <= conv_d;
      conv_valid_q <= conv_valid_d;
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (w_push),
    .pop   (m_ready),
    .wdata (conv_q),
    .rdata (m_data),
    .empty (w_empty),
    .full  (w_full),
    .level (fifo_level)
  );

  assign m_valid    = ~w_empty;
  assign sat_sticky = sat_q;
  assign ovf_sticky = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_out_stage.sv
`default_nettype none
// ==========================================================================
// tb_fir_decim_out_stage: directed checks on a DECIM=1 and a DECIM=4 instance. Rev 1.0
// ==========================================================================
module tb_fir_decim_out_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] a_din;  logic a_vld, a_flush, a_clr, a_rdy;
  logic [15:0] a_data; logic a_mv;  logic [3:0] a_lvl; logic a_sat, a_ovf;
  logic [31:0] b_din;  logic b_vld, b_flush, b_clr, b_rdy;
  logic [15:0] b_data; logic b_mv;  logic [3:0] b_lvl; logic b_sat, b_ovf;

  int checks = 0;
  int errors = 0;

  fir_decim_out_stage #(.DECIM(1), .FIFO_DEPTH(8), .IN_W(32), .OUT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_vld), .flush(a_flush),
    .clr_flags(a_clr), .m_data(a_data), .m_valid(a_mv), .m_ready(a_rdy),
    .fifo_level(a_lvl), .sat_sticky(a_sat), .ovf_sticky(a_ovf));

  fir_decim_out_stage #(.DECIM(4), .FIFO_DEPTH(8), .IN_W(32), .OUT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_vld), .flush(b_flush),
    .clr_flags(b_clr), .m_data(b_data), .m_valid(b_mv), .m_ready(b_rdy),
    .fifo_level(b_lvl), .sat_sticky(b_sat), .ovf_sticky(b_ovf));

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if ({a_mv, a_data, a_lvl} !== 21'd0) begin errors++;
      $display("FAIL reset_out got mv=%0b data=%h lvl=%0d exp 0/0000/0", a_mv, a_data, a_lvl); end
    checks++; if ({a_sat, a_ovf, b_sat, b_ovf, b_mv} !== 5'd0) begin errors++;
      $display("FAIL reset_flags got %b exp 00000", {a_sat, a_ovf, b_sat, b_ovf, b_mv}); end
    step;
    @(negedge clk) rst_n = 1'b1;
    step;
  endtask

  task automatic test_rounding;
    logic [31:0] vin  [6] = '{32'h04000000, 32'h00000800, 32'h000007FF,
                              32'hFFFFF800, 32'h08000000, 32'h80000000};
    logic [15:0] vexp [6] = '{16'h4000, 16'h0001, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    a_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_din = vin[i]; a_vld = 1'b1; step;
      a_vld = 1'b0; step;
      checks++; if (a_mv !== 1'b1 || a_data !== vexp[i]) begin errors++;
        $display("FAIL round[%0d] din=%h got mv=%0b data=%h exp 1/%h", i, vin[i], a_mv, a_data, vexp[i]); end
      if (i == 3) begin
        checks++; if (a_sat !== 1'b0) begin errors++;
          $display("FAIL sat_early got %0b exp 0", a_sat); end
      end
      if (i == 4) begin
        checks++; if (a_sat !== 1'b1) begin errors++;
          $display("FAIL sat_set got %0b exp 1", a_sat); end
      end
      step;
    end
    checks++; if (a_mv !== 1'b0) begin errors++;
      $display("FAIL round_drained got mv=%0b exp 0", a_mv); end
  endtask

  task automatic test_decimation;
    b_rdy = 1'b1;
    for (int half = 0; half < 2; half++) begin
      logic [15:0] got[$];
      int          ts[$];
      int          n = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        if (n < 16 && (half == 0 || cyc % 2 == 0)) begin
          b_din = 32'(n) << 12; b_vld = 1'b1; n++;
        end else begin
          b_vld = 1'b0;
        end
        step;
        if (b_mv) begin got.push_back(b_data); ts.push_back(cyc); end
      end
      checks++; if (got.size() != 4) begin errors++;
        $display("FAIL decim_count[%0d] got %0d exp 4", half, got.size()); end
      for (int k = 0; k < got.size() && k < 4; k++) begin
        checks++; if (got[k] !== 16'(4 * k)) begin errors++;
          $display("FAIL decim_val[%0d][%0d] got %h exp %h", half, k, got[k], 16'(4 * k)); end
      end
      if (ts.size() >= 2) begin
        checks++; if (ts[1] - ts[0] != (half ? 8 : 4)) begin errors++;
          $display("FAIL decim_gap[%0d] got %0d exp %0d", half, ts[1] - ts[0], half ? 8 : 4); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] got[$];
    a_rdy = 1'b0;
    for (int n = 1; n <= 10; n++) begin a_din = 32'(n) << 12; a_vld = 1'b1; step; end
    a_vld = 1'b0; step; step;
    checks++; if (a_lvl !== 4'd8 || a_ovf !== 1'b1) begin errors++;
      $display("FAIL bp_full got lvl=%0d ovf=%0b exp 8/1", a_lvl, a_ovf); end
    a_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (a_mv) got.push_back(a_data);
      step;
    end
    checks++; if (got.size() != 8) begin errors++;
      $display("FAIL bp_count got %0d exp 8", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++; if (got[k] !== 16'(k + 1)) begin errors++;
        $display("FAIL bp_order[%0d] got %h exp %h", k, got[k], 16'(k + 1)); end
    end
  endtask

  task automatic test_flush;
    a_rdy = 1'b0;
    for (int n = 1; n <= 5; n++) begin a_din = 32'(n) << 12; a_vld = 1'b1; step; end
    a_vld = 1'b0; step; step;
    checks++; if (a_lvl !== 4'd5) begin errors++;
      $display("FAIL flush_pre_lvl got %0d exp 5", a_lvl); end
    a_flush = 1'b1; a_din = 32'h00005000; a_vld = 1'b1; step;
    a_flush = 1'b0; a_vld = 1'b0;
    checks++; if (a_mv !== 1'b0 || a_lvl !== 4'd0) begin errors++;
      $display("FAIL flush_empty got mv=%0b lvl=%0d exp 0/0", a_mv, a_lvl); end
    checks++; if (a_sat !== 1'b1 || a_ovf !== 1'b1) begin errors++;
      $display("FAIL flush_flags got sat=%0b ovf=%0b exp 1/1", a_sat, a_ovf); end
    step; step;
    checks++; if (a_lvl !== 4'd0) begin errors++;
      $display("FAIL flush_discard got lvl=%0d exp 0", a_lvl); end
    a_clr = 1'b1; step; a_clr = 1'b0;
    checks++; if (a_sat !== 1'b0 || a_ovf !== 1'b0) begin errors++;
      $display("FAIL clr_flags got sat=%0b ovf=%0b exp 0/0", a_sat, a_ovf); end

    // Phase restart on the decimating instance: without the flush, 0x9000 would land on phase 3.
    b_rdy = 1'b0;
    b_din = 32'h00005000; b_vld = 1'b1; step;
    b_din = 32'h00006000; step;
    b_flush = 1'b1; b_din = 32'h00007000; step;
    b_flush = 1'b0; b_vld = 1'b0;
    checks++; if (b_mv !== 1'b0 || b_lvl !== 4'd0) begin errors++;
      $display("FAIL flush4_empty got mv=%0b lvl=%0d exp 0/0", b_mv, b_lvl); end
    b_din = 32'h00009000; b_vld = 1'b1; step;
    b_vld = 1'b0; step;
    checks++; if (b_mv !== 1'b1 || b_data !== 16'h0009) begin errors++;
      $display("FAIL flush4_phase got mv=%0b data=%h exp 1/0009", b_mv, b_data); end
    b_flush = 1'b1; step; b_flush = 1'b0;
  endtask

  task automatic test_full_pop;
    logic [15:0] got[$];
    a_rdy = 1'b0;
    for (int n = 1; n <= 9; n++) begin a_din = 32'(n) << 12; a_vld = 1'b1; step; end
    a_vld = 1'b0;
    checks++; if (a_lvl !== 4'd8 || a_ovf !== 1'b0) begin errors++;
      $display("FAIL fp_pre got lvl=%0d ovf=%0b exp 8/0", a_lvl, a_ovf); end
    a_rdy = 1'b1; step;
    a_rdy = 1'b0;
    checks++; if (a_lvl !== 4'd8 || a_ovf !== 1'b0 || a_data !== 16'h0002) begin errors++;
      $display("FAIL fp_post got lvl=%0d ovf=%0b data=%h exp 8/0/0002", a_lvl, a_ovf, a_data); end
    step;
    checks++; if (a_data !== 16'h0002) begin errors++;
      $display("FAIL fp_stable got data=%h exp 0002", a_data); end
    a_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (a_mv) got.push_back(a_data);
      step;
    end
    checks++; if (got.size() != 8) begin errors++;
      $display("FAIL fp_count got %0d exp 8", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++; if (got[k] !== 16'(k + 2)) begin errors++;
        $display("FAIL fp_order[%0d] got %h exp %h", k, got[k], 16'(k + 2)); end
    end
  endtask

  task automatic test_async_reset;
    a_rdy = 1'b0;
    a_din = 32'h08000000; a_vld = 1'b1; step;
    a_din = 32'h00001000; step;
    a_din = 32'h00002000; step;
    a_vld = 1'b0; step; step;
    checks++; if (a_lvl !== 4'd3 || a_sat !== 1'b1) begin errors++;
      $display("FAIL ar_pre got lvl=%0d sat=%0b exp 3/1", a_lvl, a_sat); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({a_mv, a_data, a_lvl, a_sat, a_ovf} !== 23'd0) begin errors++;
      $display("FAIL ar_clear got mv=%0b data=%h lvl=%0d sat=%0b ovf=%0b exp all 0",
               a_mv, a_data, a_lvl, a_sat, a_ovf); end
    #2 rst_n = 1'b1;
    a_rdy = 1'b1;
    a_din = 32'h00003000; a_vld = 1'b1; step;
    a_vld = 1'b0;
    checks++; if (a_mv !== 1'b0) begin errors++;
      $display("FAIL ar_lat1 got mv=%0b exp 0", a_mv); end
    step;
    checks++; if (a_mv !== 1'b1 || a_data !== 16'h0003) begin errors++;
      $display("FAIL ar_first got mv=%0b data=%h exp 1/0003", a_mv, a_data); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_din = '0; a_vld = 1'b0; a_flush = 1'b0; a_clr = 1'b0; a_rdy = 1'b0;
    b_din = '0; b_vld = 1'b0; b_flush = 1'b0; b_clr = 1'b0; b_rdy = 1'b0;
    test_reset;
    test_rounding;
    test_decimation;
    test_backpressure;
    test_flush;
    test_full_pop;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
